sdfm_input_ctrl: RTL and testbench

//  Input sequencer for one sigma-delta filter channel. Synchronises the external

---
 rtl/sdfm_pkg.sv | 18 +
 rtl/sdfm_input_ctrl_if.sv | 24 ++
 rtl/sdfm_sync.sv | 20 ++
 rtl/sdfm_input_ctrl.sv | 134 +++++++++++++
 tb/tb_sdfm_input_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sdfm_pkg.sv
// Shared encodings for the sigma-delta input sequencer: input modes, FSM states, divider width.
package sdfm_pkg;

  localparam logic [1:0] INMODE_RISE = 2'b00;
  localparam logic [1:0] INMODE_FALL = 2'b01;
  localparam logic [1:0] INMODE_RSVD = 2'b10;
  localparam logic [1:0] INMODE_INT  = 2'b11;

  localparam int SDFM_CLKDIV_W = 4;

  typedef enum logic [1:0] {
    ICTL_IDLE = 2'b00,
    ICTL_ARM  = 2'b01,
    ICTL_RUN  = 2'b10,
    ICTL_FAIL = 2'b11
  } ictl_state_t;

endpackage

// File: rtl/sdfm_input_ctrl_if.sv
// Channel config in, sample stream and status out; master = register/filter side, slave = sequencer.
interface sdfm_input_ctrl_if;
  import sdfm_pkg::*;

  logic                     reg_en;
  logic [1:0]               reg_inmode;
  logic [SDFM_CLKDIV_W-1:0] reg_clkdiv;
  logic                     clk_fail_clr;
  logic                     sd_strobe;
  logic                     sd_bit;
  logic                     sd_clk_out;
  logic                     clk_fail;

  modport master (
    output reg_en, reg_inmode, reg_clkdiv, clk_fail_clr,
    input  sd_strobe, sd_bit, sd_clk_out, clk_fail
  );

  modport slave (
    input  reg_en, reg_inmode, reg_clkdiv, clk_fail_clr,
    output sd_strobe, sd_bit, sd_clk_out, clk_fail
  );

endinterface

// File: rtl/sdfm_sync.sv
// Pin synchroniser, STAGES flops deep; latency STAGES cycles; no backpressure.
module sdfm_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/sdfm_input_ctrl.sv
// Sigma-delta input sequencer: one strobe + data bit per modulator clock; pin edge to strobe
// is SYNC_STAGES+1 cycles; no backpressure, the filter must accept every strobe.
module sdfm_input_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic             SYSCLK,
  input  logic             SYSRSTn,
  input  logic             DSDIN,
  input  logic             SDCLK,
  sdfm_input_ctrl_if.slave bus
);
  import sdfm_pkg::*;

  ictl_state_t              state, state_n;
  logic [1:0]               mode_q;
  logic [SDFM_CLKDIV_W-1:0] cnt, cnt_n, div_q, div_q_n;
  logic [TIMEOUT_W-1:0]     wd, wd_n, wd_inc;
  logic                     clk_out_q, clk_out_n;
  logic                     strobe_q, strobe_n, bit_q, bit_n, fail_q, fail_n;
  logic                     ss_clk, ss_dat, ss_clk_d;
  logic                     rise, fall, qual, enabled, mode_chg, int_mode;

  sdfm_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(SYSCLK), .rst_n(SYSRSTn), .d(SDCLK), .q(ss_clk)
  );

  sdfm_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(SYSCLK), .rst_n(SYSRSTn), .d(DSDIN), .q(ss_dat)
  );

  assign rise     = ss_clk & ~ss_clk_d;
  assign fall     = ~ss_clk & ss_clk_d;
  assign enabled  = bus.reg_en && (bus.reg_inmode != INMODE_RSVD);
  assign mode_chg = bus.reg_inmode != mode_q;
  assign int_mode = bus.reg_inmode == INMODE_INT;
  assign qual     = (bus.reg_inmode == INMODE_RISE) ? rise :
                    (bus.reg_inmode == INMODE_FALL) ? fall : 1'b0;
  assign wd_inc   = (&wd) ? wd : wd + 1'b1;

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state     <= ICTL_IDLE;
      mode_q    <= INMODE_RISE;
      cnt       <= '0;
      div_q     <= '0;
      wd        <= '0;
      clk_out_q <= 1'b0;
      strobe_q  <= 1'b0;
      bit_q     <= 1'b0;
      fail_q    <= 1'b0;
      ss_clk_d  <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= bus.reg_inmode;
      cnt       <= cnt_n;
      div_q     <= div_q_n;
      wd        <= wd_n;
      clk_out_q <= clk_out_n;
      strobe_q  <= strobe_n;
      bit_q     <= bit_n;
      fail_q    <= fail_n;
      ss_clk_d  <= ss_clk;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_q_n   = div_q;
    wd_n      = wd;
    clk_out_n = clk_out_q;
    strobe_n  = 1'b0;
    bit_n     = 1'b0;
    fail_n    = fail_q & ~bus.clk_fail_clr;
    if (!enabled) begin
      state_n   = ICTL_IDLE;
      cnt_n     = '0;
      wd_n      = '0;
      clk_out_n = 1'b0;
    end else if (state == ICTL_IDLE || mode_chg) begin
      state_n   = ICTL_ARM;
      cnt_n     = '0;
      div_q_n   = bus.reg_clkdiv;
      wd_n      = '0;
      clk_out_n = 1'b0;
    end else if (state == ICTL_FAIL) begin
      if (bus.clk_fail_clr) begin
        state_n = ICTL_ARM;
        div_q_n = bus.reg_clkdiv;
      end
    end else if (int_mode) begin
      // div_q only reloads at wrap so a clkdiv write never shortens the current half-period
      if (cnt == div_q) begin
        cnt_n     = '0;
        div_q_n   = bus.reg_clkdiv;
        clk_out_n = ~clk_out_q;
        if (state == ICTL_ARM) begin
          if (!clk_out_q) state_n = ICTL_RUN;
        end else if (clk_out_q) begin
          strobe_n = 1'b1;
          bit_n    = ss_dat;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else if (qual) begin
      wd_n = '0;
      if (state == ICTL_ARM) begin
        state_n = ICTL_RUN;
      end else begin
        strobe_n = 1'b1;
        bit_n    = ss_dat;
      end
    end else if (wd_inc == TIMEOUT_W'(TIMEOUT)) begin
      wd_n = '0;
      if (bus.clk_fail_clr) begin
        state_n = ICTL_ARM;
      end else begin
        state_n = ICTL_FAIL;
        fail_n  = 1'b1;
      end
    end else begin
      wd_n = wd_inc;
    end
  end

  assign bus.sd_strobe  = strobe_q;
  assign bus.sd_bit     = bit_q;
  assign bus.sd_clk_out = clk_out_q;
  assign bus.clk_fail   = fail_q;

endmodule

// File: tb/tb_sdfm_input_ctrl.sv
// Directed bench for sdfm_input_ctrl: external-clock modes, internal divider, watchdog, re-arm paths.
module tb_sdfm_input_ctrl;

  logic SYSCLK = 1'b0;
  logic SYSRSTn;
  logic DSDIN;
  logic SDCLK;

  sdfm_input_ctrl_if bus();

  sdfm_input_ctrl u_dut (
    .SYSCLK (SYSCLK),
    .SYSRSTn(SYSRSTn),
    .DSDIN  (DSDIN),
    .SDCLK  (SDCLK),
    .bus    (bus)
  );

  always #5 SYSCLK = ~SYSCLK;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int rise_q[$];
  int fall_q[$];
  int strb_cyc[$];
  int strb_bit[$];

  always @(posedge SYSCLK) cyc <= cyc + 1;

  always @(negedge SYSCLK) begin
    if (bus.sd_strobe) begin
      strb_cyc.push_back(cyc);
      strb_bit.push_back(int'(bus.sd_bit));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  // SDCLK = SYSCLK/10, high for 5 cycles; DSDIN moves 2 cycles before each rise, so period p carries bit p%2
  task automatic drive_periods(input int n);
    rise_q.delete();
    fall_q.delete();
    strb_cyc.delete();
    strb_bit.delete();
    DSDIN = 1'b0;
    step();
    step();
    for (int p = 0; p < n; p++) begin
      for (int o = 0; o < 10; o++) begin
        if (o == 0) begin SDCLK = 1'b1; rise_q.push_back(cyc); end
        if (o == 5) begin SDCLK = 1'b0; fall_q.push_back(cyc); end
        if (o == 8) DSDIN = ((p + 1) % 2) != 0;
        step();
      end
    end
    repeat (4) step();
  endtask

  // First edge is discarded by ARM; every later edge strobes 3 cycles after the pin moved
  task automatic check_run(input string tag, input bit use_fall, input int n_exp);
    check({tag, "_count"}, strb_cyc.size(), n_exp);
    for (int i = 0; i < n_exp && i < strb_cyc.size(); i++) begin
      check({tag, "_cyc"}, strb_cyc[i], (use_fall ? fall_q[i+1] : rise_q[i+1]) + 3);
      check({tag, "_bit"}, strb_bit[i], (i + 1) % 2);
    end
  endtask

  task automatic set_mode(input logic [1:0] mode);
    bus.reg_en = 1'b0;
    step();
    step();
    bus.reg_inmode = mode;
    bus.reg_en     = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    int t_en;
    int last_stb;
    int exp_clk;
    int exp_stb;

    SYSRSTn          = 1'b0;
    DSDIN            = 1'b0;
    SDCLK            = 1'b0;
    bus.reg_en       = 1'b0;
    bus.reg_inmode   = 2'b00;
    bus.reg_clkdiv   = 4'd0;
    bus.clk_fail_clr = 1'b0;
    repeat (3) step();
    SYSRSTn = 1'b1;
    step();
    check("rst_strobe", bus.sd_strobe, 0);
    check("rst_bit", bus.sd_bit, 0);
    check("rst_clk_out", bus.sd_clk_out, 0);
    check("rst_clk_fail", bus.clk_fail, 0);

    set_mode(2'b00);
    drive_periods(5);
    check_run("m00", 1'b0, 4);

    set_mode(2'b01);
    drive_periods(5);
    check_run("m01", 1'b1, 4);

    // Internal clock, div 3: toggles every 4 cycles; clkdiv->0 one cycle after the third toggle
    bus.reg_en = 1'b0;
    DSDIN      = 1'b1;
    step();
    step();
    bus.reg_inmode = 2'b11;
    bus.reg_clkdiv = 4'd3;
    bus.reg_en     = 1'b1;
    t_en = cyc;
    for (int o = 1; o <= 24; o++) begin
      step();
      check("m11_cyc_offset", cyc - t_en, o);
      exp_clk = (o <= 16) ? ((o - 1) / 4) % 2 : (o - 17) % 2;
      exp_stb = (o == 9 || (o >= 17 && (o % 2) == 1)) ? 1 : 0;
      check("m11_clk_out", bus.sd_clk_out, exp_clk);
      check("m11_strobe", bus.sd_strobe, exp_stb);
      if (exp_stb == 1) check("m11_bit", bus.sd_bit, 1);
      if (o == 14) bus.reg_clkdiv = 4'd0;
    end
    SYSRSTn = 1'b0;
    #1;
    check("m11_async_rst_clk_out", bus.sd_clk_out, 0);
    check("m11_async_rst_strobe", bus.sd_strobe, 0);
    step();
    SYSRSTn = 1'b1;

    // Watchdog: fail flagged 255 cycles after the strobe of the last detected edge
    set_mode(2'b00);
    drive_periods(3);
    check_run("wd_pre", 1'b0, 2);
    last_stb = rise_q[2] + 3;
    while (cyc < last_stb + 254) step();
    check("wd_before_expiry", bus.clk_fail, 0);
    step();
    check("wd_expiry", bus.clk_fail, 1);
    repeat (20) step();
    check("wd_sticky", bus.clk_fail, 1);
    check("wd_no_strobes", strb_cyc.size(), 2);
    bus.clk_fail_clr = 1'b1;
    step();
    bus.clk_fail_clr = 1'b0;
    check("wd_clear", bus.clk_fail, 0);
    drive_periods(3);
    check_run("wd_rearm", 1'b0, 2);

    // Clear pulse landing on the expiry cycle: no fail, re-armed
    last_stb = rise_q[2] + 3;
    while (cyc < last_stb + 254) step();
    bus.clk_fail_clr = 1'b1;
    step();
    bus.clk_fail_clr = 1'b0;
    check("clr_at_expiry", bus.clk_fail, 0);
    repeat (5) step();
    check("clr_at_expiry_late", bus.clk_fail, 0);
    drive_periods(3);
    check_run("clr_rearm", 1'b0, 2);

    bus.reg_en = 1'b0;
    step();
    bus.reg_en = 1'b1;
    check("en_glitch_strobe", bus.sd_strobe, 0);
    step();
    drive_periods(3);
    check_run("en_glitch_rearm", 1'b0, 2);

    SYSRSTn = 1'b0;
    #1;
    check("rst_mid_strobe", bus.sd_strobe, 0);
    check("rst_mid_clk_fail", bus.clk_fail, 0);
    step();
    SYSRSTn = 1'b1;
    step();
    drive_periods(3);
    check_run("rst_rearm", 1'b0, 2);

    set_mode(2'b10);
    drive_periods(4);
    check("m10_no_strobes", strb_cyc.size(), 0);
    check("m10_clk_out", bus.sd_clk_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
